// File: rtl/exec_pipe.sv
// Two-stage EX/WB datapath: regfile read, operand select, ALU, WB register.
// Define EXEC_PIPE_FORWARD_EN to bypass the pending WB result into EX reads.
module exec_pipe #(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 5,
  parameter int A0_ADDR   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 hold,
  input  logic [ADD_WIDTH-1:0] rs1,
  input  logic [ADD_WIDTH-1:0] rs2,
  input  logic [ADD_WIDTH-1:0] rd,
  input  logic                 reg_write,
  input  logic                 alu_src,
  input  logic [2:0]           alu_ctrl,
  input  logic [WIDTH-1:0]     imm_op,
  output logic                 wb_valid,
  output logic [ADD_WIDTH-1:0] wb_rd,
  output logic [WIDTH-1:0]     wb_data,
  output logic                 eq,
  output logic [WIDTH-1:0]     a0
);

  localparam int DEPTH = 2 ** ADD_WIDTH;
  localparam int SW    = $clog2(WIDTH);
  localparam logic [ADD_WIDTH-1:0] A0 = A0_ADDR[ADD_WIDTH-1:0];

  logic [WIDTH-1:0] rf [DEPTH];
  logic             wb_we;
  logic             wr_en;
  logic             accept;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] alu;

  assign in_ready = ~hold;
  assign accept   = in_valid & in_ready;
  assign wr_en    = wb_valid & wb_we & (wb_rd != '0);
  assign a0       = rf[A0];

  always_comb begin
    rd1 = (rs1 == '0) ? '0 : rf[rs1];
    rd2 = (rs2 == '0) ? '0 : rf[rs2];
`ifdef EXEC_PIPE_FORWARD_EN
    if (wr_en && wb_rd == rs1) rd1 = wb_data;
    if (wr_en && wb_rd == rs2) rd2 = wb_data;
`endif
  end

  assign op1 = rd1;
  assign op2 = alu_src ? imm_op : rd2;

  always_comb begin
    alu = '0;
    unique case (alu_ctrl)
      3'b000: alu = op1 + op2;
      3'b001: alu = op1 - op2;
      3'b010: alu = op1 & op2;
      3'b011: alu = op1 | op2;
      3'b100: alu = op1 ^ op2;
      3'b101: alu = {{(WIDTH-1){1'b0}},
                     $signed(op1) < $signed(op2)};
      3'b110: alu = op1 << op2[SW-1:0];
      3'b111: alu = {{(WIDTH-1){1'b0}}, op1 < op2};
    endcase
  end

  // x0 is never written, so its entry stays at the reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      eq       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else begin
      if (wr_en) rf[wb_rd] <= wb_data;
      wb_valid <= accept;
      wb_we    <= accept & reg_write;
      if (accept) begin
        wb_rd   <= rd;
        wb_data <= alu;
        eq      <= (op1 == op2);
      end
    end
  end

endmodule

// File: tb/tb_exec_pipe.sv
// Scoreboard bench for exec_pipe: driver pushes expected WB results,
// a negedge monitor pops and compares whenever wb_valid is high.
module tb_exec_pipe;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          hold;
  logic [AW-1:0] rs1, rs2, rd;
  logic          reg_write;
  logic          alu_src;
  logic [2:0]    alu_ctrl;
  logic [W-1:0]  imm_op;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [W-1:0]  wb_data;
  logic          eq;
  logic [W-1:0]  a0;

  typedef struct {
    logic [AW-1:0] rd;
    logic [W-1:0]  data;
    logic          eq;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  exec_pipe #(.WIDTH(W), .ADD_WIDTH(AW), .A0_ADDR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .hold(hold), .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_write(reg_write), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
    .imm_op(imm_op), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .eq(eq), .a0(a0)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected got rd=%0d data=%h want none",
                 wb_rd, wb_data);
      end else begin
        e = exp_q.pop_front();
        if (wb_rd !== e.rd || wb_data !== e.data || eq !== e.eq) begin
          failures++;
          $display("FAIL wb got rd=%0d data=%h eq=%b want rd=%0d data=%h eq=%b",
                   wb_rd, wb_data, eq, e.rd, e.data, e.eq);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int s1, input int s2, input int d,
                       input logic we, input logic src,
                       input logic [2:0] ctrl, input logic [W-1:0] imm,
                       input logic [W-1:0] xdata, input logic xeq);
    exp_t e;
    rs1 = AW'(s1); rs2 = AW'(s2); rd = AW'(d);
    reg_write = we; alu_src = src; alu_ctrl = ctrl; imm_op = imm;
    in_valid = 1'b1;
    e.rd = AW'(d); e.data = xdata; e.eq = xeq;
    exp_q.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] b2b;
`ifdef EXEC_PIPE_FORWARD_EN
    b2b = 32'd14;
`else
    b2b = 32'd0;
`endif
    rst = 1'b1; in_valid = 1'b0; hold = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; reg_write = 1'b0;
    alu_src = 1'b0; alu_ctrl = 3'd0; imm_op = '0;
    step(); step();
    rst = 1'b0;
    step(); step(); step();
    check("rst_wb_valid", W'(wb_valid), 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_eq", W'(eq), 0);
    check("rst_a0", a0, 0);
    check("rst_in_ready", W'(in_ready), 1);

    issue(0, 0, 10, 1, 1, 3'b000, 32'd5, 32'd5, 1'b0);
    step();
    check("a0_after_addi", a0, 32'd5);

    issue(0, 0, 1, 1, 1, 3'b000, 32'd7, 32'd7, 1'b0);
    issue(1, 1, 2, 1, 0, 3'b000, 32'd0, b2b, 1'b1);
    issue(0, 0, 5, 1, 1, 3'b000, 32'd7, 32'd7, 1'b0);
    step();
    issue(5, 5, 6, 1, 0, 3'b000, 32'd0, 32'd14, 1'b1);

    issue(0, 0, 0, 1, 1, 3'b000, 32'h55, 32'h55, 1'b0);
    issue(0, 0, 3, 1, 0, 3'b000, 32'd0, 32'd0, 1'b1);

    hold = 1'b1;
    rs1 = '0; rs2 = '0; rd = 5'd10; reg_write = 1'b1;
    alu_src = 1'b1; alu_ctrl = 3'b000; imm_op = 32'd9;
    in_valid = 1'b1;
    #1;
    check("hold_in_ready", W'(in_ready), 0);
    step();
    check("hold_wb_valid1", W'(wb_valid), 0);
    step();
    check("hold_wb_valid2", W'(wb_valid), 0);
    check("hold_a0", a0, 32'd5);
    hold = 1'b0;
    issue(0, 0, 10, 1, 1, 3'b000, 32'd9, 32'd9, 1'b0);
    step();
    check("a0_after_hold", a0, 32'd9);

    issue(0, 0, 8, 1, 1, 3'b001, 32'd1, 32'hFFFF_FFFF, 1'b0);
    step();
    issue(8, 0, 9, 1, 1, 3'b101, 32'd1, 32'd1, 1'b0);
    issue(8, 0, 9, 1, 1, 3'b111, 32'd1, 32'd0, 1'b0);
    issue(0, 0, 11, 1, 1, 3'b000, 32'd1, 32'd1, 1'b0);
    step();
    issue(11, 0, 12, 1, 1, 3'b110, 32'd33, 32'd2, 1'b0);
    issue(0, 0, 13, 1, 1, 3'b000, 32'd9, 32'd9, 1'b0);
    step();
    issue(13, 0, 14, 1, 1, 3'b100, 32'd9, 32'd0, 1'b1);
    issue(13, 0, 14, 1, 1, 3'b010, 32'd12, 32'd8, 1'b0);
    issue(13, 0, 15, 1, 1, 3'b011, 32'd4, 32'd13, 1'b0);
    issue(13, 0, 16, 0, 1, 3'b000, 32'd1, 32'd10, 1'b0);

    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    check("pre_rst_a0", a0, 0);
    issue(0, 0, 10, 1, 1, 3'b000, 32'h33, 32'h33, 1'b0);
    rst = 1'b1;
    rs1 = '0; rd = 5'd10; reg_write = 1'b1;
    alu_src = 1'b1; alu_ctrl = 3'b000; imm_op = 32'h44;
    in_valid = 1'b1;
    step();
    check("midrst_wb_valid", W'(wb_valid), 0);
    check("midrst_a0", a0, 0);
    check("midrst_wb_data", wb_data, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    step(); step();
    check("post_rst_a0", a0, 0);
    check("post_rst_wb_valid", W'(wb_valid), 0);
    check("queue_empty", W'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
